// File: rtl/axi_rd_mem_slave.sv
// AXI4 read-channel slave in front of a synchronous single-port memory
// with one cycle of read latency. It handles one burst at a time and
// returns one R beat per memory read. FIXED, INCR and WRAP bursts are
// supported. An illegal request still returns every beat of the burst,
// but each beat carries SLVERR and zero data.
module axi_rd_mem_slave #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int          BYTES = DATA_W / 8;
  localparam int          OFS   = $clog2(BYTES);
  localparam logic [2:0]  OFS3  = 3'(OFS);
  localparam logic [1:0]  RESP_OKAY   = 2'd0;
  localparam logic [1:0]  RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, RESP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cur_addr;
  logic [7:0]          len;
  logic [7:0]          cnt;
  logic [2:0]          size;
  logic [1:0]          burst;
  logic                err;

  logic [ADDR_W-1:0]   nxt_addr;
  logic                ar_err;
  logic                beat_err;

  // Address of the beat that follows cur, wrapped modulo 2**ADDR_W
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] cur,
                                                  input logic [2:0]        sz_log,
                                                  input logic [7:0]        blen,
                                                  input logic [1:0]        btype);
    logic [ADDR_W-1:0] sz;
    logic [ADDR_W-1:0] wb;
    sz = ADDR_W'(1) << sz_log;
    wb = (ADDR_W'(blen) + ADDR_W'(1)) << sz_log;
    case (btype)
      2'd1:    next_addr = (cur & ~(sz - ADDR_W'(1))) + sz;
      2'd2:    next_addr = (cur & ~(wb - ADDR_W'(1))) | ((cur + sz) & (wb - ADDR_W'(1)));
      default: next_addr = cur;
    endcase
  endfunction

  // True when a byte address falls outside the memory
  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    out_of_range = (a >> (MEM_AW + OFS)) != '0;
  endfunction

  // Errors that are known from the AR fields alone
  function automatic logic req_illegal(input logic [ADDR_W-1:0] a,
                                       input logic [7:0]        blen,
                                       input logic [2:0]        sz_log,
                                       input logic [1:0]        btype);
    logic wrap_len_bad;
    logic wrap_unaligned;
    wrap_len_bad   = !(blen == 8'd1 || blen == 8'd3 || blen == 8'd7 || blen == 8'd15);
    wrap_unaligned = (a & ((ADDR_W'(1) << sz_log) - ADDR_W'(1))) != '0;
    req_illegal = (sz_log > OFS3) || (btype == 2'd3) ||
                  (btype == 2'd2 && (wrap_len_bad || wrap_unaligned));
  endfunction

  // Beat-address and error decisions feeding the next memory fetch
  always_comb begin
    nxt_addr = next_addr(cur_addr, size, len, burst);
    ar_err   = req_illegal(araddr, arlen, arsize, arburst) || out_of_range(araddr);
    beat_err = err || out_of_range(nxt_addr);
  end

  // Burst sequencer: AR capture, memory strobe, R beat hand-off
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rresp    <= RESP_OKAY;
      rid      <= '0;
      rdata    <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      cur_addr <= '0;
      len      <= '0;
      cnt      <= '0;
      size     <= '0;
      burst    <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arvalid && arready) begin
            arready  <= 1'b0;
            rid      <= arid;
            cur_addr <= araddr;
            len      <= arlen;
            size     <= arsize;
            burst    <= arburst;
            cnt      <= '0;
            err      <= ar_err;
            mem_en   <= !ar_err;
            mem_addr <= araddr[OFS +: MEM_AW];
            state    <= FETCH;
          end else begin
            arready  <= 1'b1;
          end
        end
        FETCH: begin
          mem_en <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          rdata  <= err ? '0 : mem_rdata;
          rresp  <= err ? RESP_SLVERR : RESP_OKAY;
          rlast  <= (cnt == len);
          rvalid <= 1'b1;
          state  <= RESP;
        end
        RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            if (rlast) begin
              arready <= 1'b1;
              state   <= IDLE;
            end else begin
              cnt      <= cnt + 8'd1;
              cur_addr <= nxt_addr;
              err      <= beat_err;
              mem_en   <= !beat_err;
              mem_addr <= nxt_addr[OFS +: MEM_AW];
              state    <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_mem_slave.sv
// Bench for axi_rd_mem_slave: a behavioural memory, and scoreboards for
// memory addresses and R beats that are filled when each AR is driven.
module tb_axi_rd_mem_slave;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int MEM_AW = 12;

  logic              clk;
  logic              rstn;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              mem_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } rbeat_t;

  rbeat_t            rq[$];
  logic [MEM_AW-1:0] mq[$];

  int total = 0;
  int bad   = 0;

  logic              hold_v = 1'b0;
  logic [DATA_W-1:0] hold_data;
  logic [1:0]        hold_resp;
  logic              hold_last;
  logic [ID_W-1:0]   hold_id;

  axi_rd_mem_slave #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Memory contents: a recognisable pattern derived from the word address
  function automatic logic [DATA_W-1:0] word(input logic [MEM_AW-1:0] a);
    word = {20'hDEADB, a, 20'h12345, a};
  endfunction

  always @(posedge clk) if (mem_en) mem_rdata <= word(mem_addr);

  // Byte address of beat i, written as an offset within the burst window
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst,
                                            input int i);
    logic [31:0] sz, wb, lower;
    sz = 32'd1 << size;
    case (burst)
      2'd1: beat_addr = (i == 0) ? start : (start / sz) * sz + 32'(i) * sz;
      2'd2: begin
        wb = (32'(len) + 32'd1) * sz;
        lower = start - (start % wb);
        beat_addr = lower + (((start - lower) + 32'(i) * sz) % wb);
      end
      default: beat_addr = start;
    endcase
  endfunction

  task automatic exp_burst(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic   e;
    logic [31:0] a;
    rbeat_t b;
    e = (size > 3'd3) || (burst == 2'd3);
    if (burst == 2'd2) begin
      if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) e = 1'b1;
      if ((addr % (32'd1 << size)) != 0) e = 1'b1;
    end
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, size, len, burst, i);
      if (a >= 32'h8000) e = 1'b1;
      b.id   = id;
      b.last = (i == int'(len));
      b.resp = e ? 2'd2 : 2'd0;
      b.data = e ? '0 : word(a[14:3]);
      rq.push_back(b);
      if (!e) mq.push_back(a[14:3]);
    end
  endtask

  task automatic drive_ar(input logic [ID_W-1:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    exp_burst(id, addr, len, size, burst);
  endtask

  task automatic wait_ar_accept();
    int t = 0;
    while (!arready && t < 50) begin @(posedge clk); #1; t++; end
    if (!arready) chk("ar_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [ID_W-1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    drive_ar(id, addr, len, size, burst);
    wait_ar_accept();
  endtask

  // Accept n beats; beat index stall_beat is held off for stall_cyc cycles
  task automatic drain(input int n, input int stall_beat, input int stall_cyc);
    for (int b = 0; b < n; b++) begin
      int t = 0;
      rready = 1'b0;
      while (!rvalid && t < 50) begin @(posedge clk); #1; t++; end
      if (!rvalid) begin
        chk("r_timeout", 64'd0, 64'd1);
        return;
      end
      if (b == stall_beat) repeat (stall_cyc) begin @(posedge clk); #1; end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
    end
  endtask

  // Monitors: memory strobes, R handshakes and R stability under back-pressure
  always @(negedge clk) begin
    if (rstn && mem_en) begin
      if (mq.size() == 0) chk("mem_en_unexpected", 64'd1, 64'd0);
      else chk("mem_addr", 64'(mem_addr), 64'(mq.pop_front()));
    end
    if (rstn && hold_v && rvalid) begin
      chk("hold_rdata", rdata, hold_data);
      chk("hold_rresp", 64'(rresp), 64'(hold_resp));
      chk("hold_rlast", 64'(rlast), 64'(hold_last));
      chk("hold_rid", 64'(rid), 64'(hold_id));
    end
    hold_v    = rstn && rvalid && !rready;
    hold_data = rdata; hold_resp = rresp; hold_last = rlast; hold_id = rid;
    if (rstn && rvalid && rready) begin
      if (rq.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
      else begin
        rbeat_t e;
        e = rq.pop_front();
        chk("rid", 64'(rid), 64'(e.id));
        chk("rdata", rdata, e.data);
        chk("rresp", 64'(rresp), 64'(e.resp));
        chk("rlast", 64'(rlast), 64'(e.last));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; arvalid = 1'b0; rready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_rid", 64'(rid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    chk("arready_after_rst", 64'(arready), 64'd1);

    // INCR with back-pressure on the second beat
    send_ar(4'd5, 32'h100, 8'd3, 3'd3, 2'd1);
    drain(4, 1, 5);
    // WRAP
    send_ar(4'd1, 32'h38, 8'd3, 3'd3, 2'd2);
    drain(4, -1, 0);
    // FIXED
    send_ar(4'd2, 32'h40, 8'd2, 3'd3, 2'd0);
    drain(3, -1, 0);
    // Reserved burst type
    send_ar(4'd6, 32'h40, 8'd1, 3'd3, 2'd3);
    drain(2, -1, 0);
    // Beat wider than the bus
    send_ar(4'd7, 32'h0, 8'd1, 3'd4, 2'd1);
    drain(2, -1, 0);
    // Runs off the end of memory on the second beat
    send_ar(4'd8, 32'h7FF8, 8'd1, 3'd3, 2'd1);
    drain(2, -1, 0);
    // WRAP with an illegal length, then WRAP misaligned
    send_ar(4'd11, 32'h40, 8'd2, 3'd3, 2'd2);
    drain(3, -1, 0);
    send_ar(4'd12, 32'h3C, 8'd3, 3'd3, 2'd2);
    drain(4, -1, 0);
    // Narrow INCR from an unaligned start
    send_ar(4'd13, 32'h105, 8'd2, 3'd2, 2'd1);
    drain(3, -1, 0);

    // Back-to-back: second AR held while the first burst is in flight
    send_ar(4'd9, 32'h300, 8'd1, 3'd3, 2'd1);
    drive_ar(4'd10, 32'h308, 8'd0, 3'd3, 2'd0);
    drain(2, -1, 0);
    chk("b2b_arready", 64'(arready), 64'd1);
    @(posedge clk); #1;
    chk("b2b_accepted", 64'(arready), 64'd0);
    arvalid = 1'b0;
    drain(1, -1, 0);

    // Reset in the middle of a long burst
    send_ar(4'd4, 32'h400, 8'd7, 3'd3, 2'd1);
    drain(1, -1, 0);
    begin
      int t = 0;
      while (!rvalid && t < 50) begin @(posedge clk); #1; t++; end
      chk("beat1_present", 64'(rvalid), 64'd1);
    end
    rstn = 1'b0;
    #1;
    chk("midrst_rvalid", 64'(rvalid), 64'd0);
    chk("midrst_arready", 64'(arready), 64'd0);
    chk("midrst_mem_en", 64'(mem_en), 64'd0);
    rq.delete();
    mq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    send_ar(4'd3, 32'h200, 8'd1, 3'd3, 2'd1);
    drain(2, -1, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("rq_empty", 64'(rq.size()), 64'd0);
    chk("mq_empty", 64'(mq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
